// File: rtl/pipe_pkg.sv
// Shared pipeline types: default datapath widths and the ID->EX entry layout.
package pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REGW_DEF  = 5;
  localparam int CTRLW_DEF = 8;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
    logic [1:0] mem_rw;
  } idex_ctrl_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc4;
    logic [XLEN_DEF-1:0] op1;
    logic [XLEN_DEF-1:0] op2;
    logic [REGW_DEF-1:0] rd;
    idex_ctrl_t          ctrl;
    logic                pred;
    logic                mem_read;
    logic                reg_write;
  } idex_entry_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: data register plus valid bit. A load takes priority over a clear.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);

  logic         r_valid;
  logic [W-1:0] r_q;

  // Data only moves on a load, so idle cycles leave the payload untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule

// File: rtl/idex_elastic_stage.sv
// ID->EX elastic pipeline register: valid/ready handshake, optional skid slot,
// synchronous flush and load-use hazard detection against the held entries.
module idex_elastic_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int CTRLW = CTRLW_DEF,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [XLEN-1:0]  i_in_pc4,
  input  logic [XLEN-1:0]  i_in_op1,
  input  logic [XLEN-1:0]  i_in_op2,
  input  logic [REGW-1:0]  i_in_rd,
  input  logic [REGW-1:0]  i_in_rs1,
  input  logic [REGW-1:0]  i_in_rs2,
  input  logic [CTRLW-1:0] i_in_ctrl,
  input  logic             i_in_pred,
  input  logic             i_in_mem_read,
  input  logic             i_in_reg_write,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_out_pc4,
  output logic [XLEN-1:0]  o_out_op1,
  output logic [XLEN-1:0]  o_out_op2,
  output logic [REGW-1:0]  o_out_rd,
  output logic [CTRLW-1:0] o_out_ctrl,
  output logic             o_out_pred,
  output logic             o_out_mem_read,
  output logic             o_out_reg_write,
  output logic             o_hazard_load_use,
  output logic [1:0]       o_occupancy
);

  typedef struct packed {
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [REGW-1:0]  rd;
    logic [CTRLW-1:0] ctrl;
    logic             pred;
    logic             mem_read;
    logic             reg_write;
  } entry_t;

  localparam int W = $bits(entry_t);

  function automatic logic ld_use(input logic v, input entry_t e,
                                  input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2);
    return v & e.mem_read & e.reg_write & (e.rd != '0) & ((e.rd == rs1) | (e.rd == rs2));
  endfunction

  entry_t     w_in, w_head, w_skid, w_head_d;
  logic       w_head_v, w_skid_v;
  logic       w_hazard, w_in_ready, w_push, w_pop;
  logic       w_head_load, w_head_load_skid, w_head_clr;
  logic       w_skid_load, w_skid_clr;
  logic       w_head_v_nxt, w_skid_v_nxt;
  logic [1:0] r_occ;

  assign w_in = {i_in_pc4, i_in_op1, i_in_op2, i_in_rd, i_in_ctrl,
                 i_in_pred, i_in_mem_read, i_in_reg_write};

  assign w_hazard = i_in_valid & (ld_use(w_head_v, w_head, i_in_rs1, i_in_rs2) |
                                  ld_use(w_skid_v, w_skid, i_in_rs1, i_in_rs2));

  // rst_n gating keeps in_ready low for the whole reset window.
  generate
    if (SKID != 0) begin : g_rdy_skid
      assign w_in_ready = rst_n & ~w_skid_v & ~w_hazard;
    end else begin : g_rdy_single
      assign w_in_ready = rst_n & (~w_head_v | i_out_ready) & ~w_hazard;
    end
  endgenerate

  assign w_push = i_in_valid & w_in_ready;
  assign w_pop  = w_head_v & i_out_ready;

  // Skid is always younger than head: on a pop it refills head before new input does.
  assign w_head_load_skid = ~i_flush & w_pop & w_skid_v;
  assign w_head_load      = w_head_load_skid |
                            (~i_flush & w_push & (~w_head_v | (w_pop & ~w_skid_v)));
  assign w_head_d         = w_head_load_skid ? w_skid : w_in;
  assign w_head_clr       = i_flush | w_pop;
  assign w_skid_load      = ~i_flush & w_push & w_head_v & ~w_pop;
  assign w_skid_clr       = i_flush | w_pop;

  pipe_slot #(.W(W)) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_head_load),
    .i_clear (w_head_clr),
    .i_d     (w_head_d),
    .o_valid (w_head_v),
    .o_q     (w_head)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.W(W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clr),
        .i_d     (w_in),
        .o_valid (w_skid_v),
        .o_q     (w_skid)
      );
    end else begin : g_no_skid
      assign w_skid_v = 1'b0;
      assign w_skid   = '0;
    end
  endgenerate

  assign w_head_v_nxt = w_head_load | (w_head_v & ~w_head_clr);
  assign w_skid_v_nxt = (SKID != 0) & (w_skid_load | (w_skid_v & ~w_skid_clr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= 2'd0;
    else        r_occ <= {1'b0, w_head_v_nxt} + {1'b0, w_skid_v_nxt};
  end

  assign o_in_ready        = w_in_ready;
  assign o_out_valid       = w_head_v;
  assign o_out_pc4         = w_head.pc4;
  assign o_out_op1         = w_head.op1;
  assign o_out_op2         = w_head.op2;
  assign o_out_rd          = w_head.rd;
  assign o_out_ctrl        = w_head.ctrl;
  assign o_out_pred        = w_head.pred;
  assign o_out_mem_read    = w_head.mem_read;
  assign o_out_reg_write   = w_head.reg_write;
  assign o_hazard_load_use = w_hazard;
  assign o_occupancy       = r_occ;

endmodule
